// File: rtl/mux4_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux4_scan_ctrl
// Purpose  : Round-robin select generator for a downstream 4x1 mux. It grants
//            one of four request channels, holds the select for DWELL clocks,
//            and flags when a selection is valid and when its dwell completes.
//            This is a Moore machine, and every output comes from a register.
// Ports    : clk       - system clock, rising edge
//            rst_n     - synchronous active-low reset
//            en        - scan enable; low aborts the current dwell
//            req[3:0]  - channel requests (bit0 = A/sel 00 .. bit3 = D/sel 11)
//            sel1/sel2 - mux select MSB/LSB
//            valid     - select holds a granted channel
//            ch_done   - one-cycle pulse on the final dwell cycle
//            busy      - FSM is not IDLE
//            grant_cnt - (MUX4_SCAN_STATUS_EN only) completed-dwell count
// Options  : `define MUX4_SCAN_STATUS_EN adds the 8-bit grant_cnt output
// Revision : 1.0 - initial release
// ============================================================================
module mux4_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic       sel1,
    output logic       sel2,
    output logic       valid,
    output logic       ch_done,
`ifdef MUX4_SCAN_STATUS_EN
    output logic       busy,
    output logic [7:0] grant_cnt
`else
    output logic       busy
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // The counter holds the number of dwell cycles still to come after the
    // current one. A grant loads DWELL-1, and the final cycle has count 0.
    localparam logic [CNT_W-1:0] C_RELOAD   = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
    // When the dwell is a single cycle, the grant cycle is also the last cycle.
    localparam logic             C_DONE_ON_ENTRY = (DWELL == 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic [1:0]       w_pick;
    logic [1:0]       w_cand;
    logic             w_pick_ok;
    logic             w_grant;

    // ------------------------------------------------------------------------
    // Round-robin pick: search from r_ptr+1 and wrap around. The loop walks
    // from the farthest candidate toward the nearest one. The last match it
    // writes is therefore the first requester in search order. Offset 4 wraps
    // back to r_ptr itself, so a lone requester is granted again.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pick    = r_ptr;
        w_cand    = r_ptr;
        w_pick_ok = |req;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_ptr + 2'(k);
            if (req[w_cand]) begin
                w_pick = w_cand;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;
        w_grant     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_valid_nxt = 1'b0;
                if (en && w_pick_ok) begin
                    w_grant = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!en) begin
                    // Abort. The pointer keeps the aborted channel, and no
                    // done pulse is produced for the partial dwell.
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                end else if (r_cnt != C_CNT_ZERO) begin
                    // The dwell continues whatever req does. The done pulse
                    // lines up with the cycle whose count is zero.
                    w_cnt_nxt  = r_cnt - C_CNT_ONE;
                    w_done_nxt = (r_cnt == C_CNT_ONE);
                end else if (w_pick_ok) begin
                    // Back-to-back grant with no idle bubble.
                    w_grant = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase

        if (w_grant) begin
            w_state_nxt = ST_HOLD;
            w_sel_nxt   = w_pick;
            w_ptr_nxt   = w_pick;
            w_cnt_nxt   = C_RELOAD;
            w_valid_nxt = 1'b1;
            w_done_nxt  = C_DONE_ON_ENTRY;
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= 2'b00;
            r_ptr   <= 2'b11;       // the first search then starts at channel 0
            r_cnt   <= C_CNT_ZERO;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign sel1    = r_sel[1];
    assign sel2    = r_sel[0];
    assign valid   = r_valid;
    assign ch_done = r_done;
    assign busy    = (r_state == ST_HOLD);

`ifdef MUX4_SCAN_STATUS_EN
    // Count completed dwells. The count advances at the end of each cycle
    // that shows a done pulse. An aborted dwell never pulses, so it is not
    // counted.
    logic [7:0] r_grant_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant_cnt <= 8'd0;
        end else if (r_done) begin
            r_grant_cnt <= r_grant_cnt + 8'd1;
        end
    end

    assign grant_cnt = r_grant_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux4_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_scan_ctrl
// Purpose  : Self-checking bench for mux4_scan_ctrl. Two instances share one
//            stimulus stream, one with DWELL=4 and one with DWELL=1. Both are
//            compared every cycle against a transaction-level reference model.
//            grant_cnt is checked as well when MUX4_SCAN_STATUS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;

    logic       sel1_a, sel2_a, valid_a, done_a, busy_a;
    logic       sel1_b, sel2_b, valid_b, done_b, busy_b;
`ifdef MUX4_SCAN_STATUS_EN
    logic [7:0] gcnt_a, gcnt_b;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux4_scan_ctrl #(.DWELL(4), .CNT_W(3)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .sel1     (sel1_a),
        .sel2     (sel2_a),
        .valid    (valid_a),
        .ch_done  (done_a),
`ifdef MUX4_SCAN_STATUS_EN
        .busy     (busy_a),
        .grant_cnt(gcnt_a)
`else
        .busy     (busy_a)
`endif
    );

    mux4_scan_ctrl #(.DWELL(1), .CNT_W(3)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .sel1     (sel1_b),
        .sel2     (sel2_b),
        .valid    (valid_b),
        .ch_done  (done_b),
`ifdef MUX4_SCAN_STATUS_EN
        .busy     (busy_b),
        .grant_cnt(gcnt_b)
`else
        .busy     (busy_b)
`endif
    );

    // ------------------------------------------------------------------------
    // Reference model: one grant is a run of `left` valid cycles on channel ch.
    // Index 0 models the DWELL=4 instance and index 1 the DWELL=1 instance.
    // ------------------------------------------------------------------------
    int m_dwell [2] = '{4, 1};
    int m_act   [2];
    int m_ch    [2];
    int m_left  [2];
    int m_last  [2];
    int m_gc    [2];

    function automatic int rr_pick(input int last, input logic [3:0] rq);
        int r;
        r = -1;
        for (int k = 1; k <= 4; k++) begin
            if (r < 0 && rq[(last + k) % 4]) r = (last + k) % 4;
        end
        return r;
    endfunction

    task automatic model_step(input bit rn, input bit e, input logic [3:0] rq);
        for (int i = 0; i < 2; i++) begin
            if (!rn) begin
                m_act[i]  = 0;
                m_ch[i]   = 0;
                m_left[i] = 0;
                m_last[i] = 3;
                m_gc[i]   = 0;
            end else begin
                if (m_act[i] != 0 && m_left[i] == 1) m_gc[i] = (m_gc[i] + 1) % 256;
                if (m_act[i] != 0 && e && m_left[i] > 1) begin
                    m_left[i] = m_left[i] - 1;
                end else if (e && rq != 4'b0000 && (m_act[i] == 0 || m_left[i] == 1)) begin
                    m_ch[i]   = rr_pick(m_last[i], rq);
                    m_last[i] = m_ch[i];
                    m_left[i] = m_dwell[i];
                    m_act[i]  = 1;
                end else begin
                    m_act[i] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit ea, eb;
        ea = (m_act[0] != 0);
        eb = (m_act[1] != 0);
        chk("d4_sel",   {30'd0, sel1_a, sel2_a}, m_ch[0]);
        chk("d4_valid", {31'd0, valid_a}, {31'd0, ea});
        chk("d4_busy",  {31'd0, busy_a},  {31'd0, ea});
        chk("d4_done",  {31'd0, done_a},  {31'd0, ea && m_left[0] == 1});
        chk("d1_sel",   {30'd0, sel1_b, sel2_b}, m_ch[1]);
        chk("d1_valid", {31'd0, valid_b}, {31'd0, eb});
        chk("d1_busy",  {31'd0, busy_b},  {31'd0, eb});
        chk("d1_done",  {31'd0, done_b},  {31'd0, eb && m_left[1] == 1});
`ifdef MUX4_SCAN_STATUS_EN
        chk("d4_gcnt",  {24'd0, gcnt_a}, m_gc[0]);
        chk("d1_gcnt",  {24'd0, gcnt_b}, m_gc[1]);
`endif
    endtask

    // Drive one cycle of inputs on the falling edge, let the rising edge act,
    // then compare at the next falling edge.
    task automatic cyc(input bit rn, input bit e, input logic [3:0] rq);
        rst_n = rn;
        en    = e;
        req   = rq;
        @(posedge clk);
        model_step(rn, e, rq);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n, input bit e, input logic [3:0] rq);
        for (int j = 0; j < n; j++) cyc(1'b1, e, rq);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 4'b0000;

        // Reset state
        cyc(1'b0, 1'b0, 4'b0000);
        cyc(1'b0, 1'b1, 4'b1111);
        chk("rst_sel",   {30'd0, sel1_a, sel2_a}, 32'd0);
        chk("rst_valid", {31'd0, valid_a}, 32'd0);

        // All channels requesting: 00,01,10,11,... with back-to-back dwells
        cyc(1'b1, 1'b1, 4'b1111);
        chk("first_grant", {30'd0, sel1_a, sel2_a}, 32'd0);
        run(20, 1'b1, 4'b1111);

        // A single requester is granted again and again without dropping valid
        run(12, 1'b1, 4'b0100);

        // Drop en two cycles into channel 01's dwell, then enable again
        cyc(1'b0, 1'b0, 4'b0000);
        run(6, 1'b1, 4'b1111);
        run(1, 1'b0, 4'b1111);
        run(6, 1'b1, 4'b1111);

        // Reset in the middle of a dwell, then restart from channel 00
        cyc(1'b0, 1'b0, 4'b0000);
        run(14, 1'b1, 4'b1111);
        cyc(1'b0, 1'b1, 4'b1111);
        chk("midrst_valid", {31'd0, valid_a}, 32'd0);
        cyc(1'b1, 1'b1, 4'b1111);
        chk("post_rst_grant", {30'd0, sel1_a, sel2_a}, 32'd0);
        run(4, 1'b1, 4'b1111);

        // Alternating channels 01/11
        run(10, 1'b1, 4'b1010);

        // Long run on one channel (grant counter wraps), then an abort
        cyc(1'b0, 1'b0, 4'b0000);
        run(300, 1'b1, 4'b0001);
        run(2, 1'b0, 4'b0001);
        run(6, 1'b1, 4'b0001);

        // Randomized traffic
        for (int j = 0; j < 3000; j++) begin
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
                4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
